fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction queue between the fetch unit and the decode/execute stage.
//  Buffers {PC, ins} pairs from fetch with a valid/ready handshake, so fetch
//  keeps running while decode stalls. Redirects (taken branch, JAL, JALR)
//  flush it, and halt freezes it.
// PARAMETERS
//  DEPTH   2   entries; power of two, >= 2
//  W       32  width of ins and of PC
// PORTS
//  CLOCK_50      in   1        system clock; all state updates on posedge
//  reset         in   1        synchronous, active-high
//  in_valid      in   1        fetch presents in_pc/in_ins
//  in_ready      out  1        queue accepts this cycle
//  in_pc         in   W        PC of fetched instruction
//  in_ins        in   W        fetched instruction word
//  flush         in   1        redirect: discard all entries (branchTaken|aluToPC|jump)
//  halt          in   1        freeze queue; no push, no pop
//  out_valid     out  1        head entry valid for decode
//  out_ready     in   1        decode consumes head this cycle
//  out_pc        out  W        head PC
//  out_ins       out  W        head instruction
//  count         out  clog2(DEPTH)+1  occupied entries
//  pd_is_branch  out  1        [FDQ_PREDECODE_EN only] head opcode == 7'b1100011
//  pd_is_jump    out  1        [FDQ_PREDECODE_EN only] head opcode == 1101111 or 1100111
// BEHAVIOUR
//  - Storage: circular buffer of DEPTH x {pc, ins}. wr_ptr and rd_ptr are
//    clog2(DEPTH) bits wide and wrap modulo DEPTH (DEPTH-1 -> 0).
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = !reset & !flush & !halt & (count < DEPTH). No same-cycle
//    pass-through: a full queue refuses a push even when a pop occurs.
//  - out_valid = (count != 0) & !halt & !flush.
//  - out_pc/out_ins driven from entry[rd_ptr] (first-word fall-through).
//    When count == 0: out_ins = 32'h0000_0013 (NOP), out_pc = 0.
//  - Latency: a push at edge N gives out_valid = 1 in the cycle after edge N,
//    which is 1 cycle. No combinational path from in_* to out_*, and none
//    from out_ready to in_ready.
//  - count update: push only gives +1; pop only gives -1; push and pop give
//    no change (both pointers advance).
//  - Priority at posedge: reset > flush > halt > normal push/pop.
//  - reset: wr_ptr = rd_ptr = 0, count = 0. While reset is high,
//    out_valid = 0 and in_ready = 0. Storage contents are don't-care.
//  - flush: next state has pointers = 0 and count = 0. A push offered in the
//    flush cycle is dropped (in_ready = 0). No pop is reported.
//  - halt: pointers, count and storage are held. out_valid = 0 and
//    in_ready = 0. Entries reappear unchanged once halt drops.
//  - reset or flush asserted mid-stream: entries already queued are discarded
//    and never presented afterwards.
//  - Full (count == DEPTH): in_ready = 0. Empty: out_valid = 0, and an
//    out_ready in that cycle is ignored.
// CONFIGURATION
//  FDQ_PREDECODE_EN defined:
//    pd_is_branch and pd_is_jump are present, decoded combinationally from
//    out_ins[6:0]. Both are forced to 0 when out_valid = 0.
//  FDQ_PREDECODE_EN undefined:
//    neither port exists. No predecode logic is built.
// TESTING
//  1 reset high 2 cycles, then low -> count=0, out_valid=0, in_ready=1, out_ins=0x00000013
//  2 push {pc=0, ins=0x00500093}, out_ready=0 -> next cycle out_valid=1, out_pc=0, count=1
//  3 DEPTH=2: push pc 0, 4, 8 with out_ready=0 -> pc 8 refused (in_ready=0 at count=2);
//    then pop twice -> outputs are 0, then 4
//  4 count=1, push pc 0x10 and pop in the same cycle -> count stays 1, head becomes pc 0x10
//  5 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; pushed word dropped
//  6 count=1, halt=1 for 3 cycles with out_ready=1 -> out_valid=0, count=1 held;
//    halt=0 -> same entry popped
//  7 (FDQ_PREDECODE_EN) head ins=0x00208463 -> pd_is_branch=1;
//    head ins=0x008000EF -> pd_is_jump=1
//  8 pointer wrap: 5 push/pop pairs at DEPTH=2 -> output order preserved, count=0 at end

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: instruction queue between fetch and decode.
// Holds {PC, ins} pairs in a DEPTH-entry circular buffer with a valid/ready
// handshake on each side, so fetch keeps running while decode stalls.
// flush (redirect) discards all entries; halt freezes the queue.
// The head entry is visible combinationally (first-word fall-through).
// Optional feature macro: FDQ_PREDECODE_EN adds the pd_is_branch/pd_is_jump
// outputs, predecoded from the head opcode.
module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_pc,
  input  logic [W-1:0]           in_ins,
  input  logic                   flush,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_pc,
  output logic [W-1:0]           out_ins,
  output logic [$clog2(DEPTH):0] count
`ifdef FDQ_PREDECODE_EN
  ,
  output logic                   pd_is_branch,
  output logic                   pd_is_jump
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [W-1:0]  NOP_INS  = W'(32'h0000_0013);

  logic [W-1:0]  pc_q  [DEPTH];
  logic [W-1:0]  ins_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Handshake qualifiers; full refuses a push even when a pop happens.
  always_comb begin
    in_ready  = !reset && !flush && !halt && (count_q < FULL);
    out_valid = !reset && !flush && !halt && (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Head presentation; empty queue shows a NOP at PC 0.
  always_comb begin
    if (count_q == '0) begin
      out_pc  = '0;
      out_ins = NOP_INS;
    end else begin
      out_pc  = pc_q[rd_ptr_q];
      out_ins = ins_q[rd_ptr_q];
    end
  end

  assign count = count_q;

  // Next pointer/occupancy state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset, only the occupancy matters.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      pc_q[wr_ptr_q]  <= in_pc;
      ins_q[wr_ptr_q] <= in_ins;
    end
  end

`ifdef FDQ_PREDECODE_EN
  // Predecode of the head opcode, gated by out_valid.
  always_comb begin
    pd_is_branch = out_valid && (out_ins[6:0] == 7'b1100011);
    pd_is_jump   = out_valid && ((out_ins[6:0] == 7'b1101111) ||
                                 (out_ins[6:0] == 7'b1100111));
  end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Testbench for fetch_decode_queue (DEPTH=2, W=32), scoreboard-based.
// Predecode checks build only when FDQ_PREDECODE_EN is defined.
module tb_fetch_decode_queue;

  logic        CLOCK_50 = 1'b0;
  logic        reset, in_valid, in_ready, flush, halt, out_valid, out_ready;
  logic [31:0] in_pc, in_ins, out_pc, out_ins;
  logic [1:0]  count;
`ifdef FDQ_PREDECODE_EN
  logic        pd_is_branch, pd_is_jump;
`endif

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t sb[$];
  ent_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  fetch_decode_queue #(.DEPTH(2), .W(32)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_ins   (in_ins),
    .flush    (flush),
    .halt     (halt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_ins  (out_ins),
    .count    (count)
`ifdef FDQ_PREDECODE_EN
    ,
    .pd_is_branch(pd_is_branch),
    .pd_is_jump  (pd_is_jump)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_ins    = ins;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; halt = 1'b0;
    drive(1'b1, 32'h0, 32'h0, 1'b1);
    tick();
    @(negedge CLOCK_50);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid2: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready2: got %b want 1", in_ready); else n_pass++;
    n_chk++; if (out_ins !== 32'h0000_0013) $display("FAIL rst_nop: got %h want 00000013", out_ins); else n_pass++;
    n_chk++; if (out_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", out_pc); else n_pass++;
    tick();
  endtask

  task automatic test_push_single();
    drive(1'b1, 32'h0, 32'h0050_0093, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (in_ready !== 1'b1) $display("FAIL p1_in_ready: got %b want 1", in_ready); else n_pass++;
    sb.push_back('{32'h0, 32'h0050_0093});
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (out_valid !== 1'b1) $display("FAIL p1_out_valid: got %b want 1", out_valid); else n_pass++;
    n_chk++; if (count !== 2'd1) $display("FAIL p1_count: got %0d want 1", count); else n_pass++;
    out_ready = 1'b1;
    e = sb.pop_front();
    n_chk++; if (out_pc !== e.pc || out_ins !== e.ins)
      $display("FAIL p1_head: got %h/%h want %h/%h", out_pc, out_ins, e.pc, e.ins); else n_pass++;
    tick();
    out_ready = 1'b0;
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0) $display("FAIL p1_drain: got %0d want 0", count); else n_pass++;
    tick();
  endtask

  task automatic test_fill();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b0);
      @(negedge CLOCK_50);
      if (i < 2) begin
        n_chk++; if (in_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b want 1", i, in_ready); else n_pass++;
        sb.push_back('{32'(i * 4), 32'hA000_0000 | 32'(i)});
      end else begin
        n_chk++; if (in_ready !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", in_ready); else n_pass++;
        n_chk++; if (count !== 2'd2) $display("FAIL fill_count: got %0d want 2", count); else n_pass++;
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge CLOCK_50);
      e = sb.pop_front();
      n_chk++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
        $display("FAIL fill_pop%0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, out_pc, out_ins, e.pc, e.ins);
      else n_pass++;
      tick();
    end
    out_ready = 1'b0;
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL fill_empty: got cnt=%0d v=%b want 0/0", count, out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_push_pop_same();
    drive(1'b1, 32'h20, 32'h0000_0113, 1'b0);
    sb.push_back('{32'h20, 32'h0000_0113});
    tick();
    drive(1'b1, 32'h10, 32'h0020_0193, 1'b1);
    @(negedge CLOCK_50);
    e = sb.pop_front();
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== e.pc)
      $display("FAIL pp_both: got rdy=%b v=%b pc=%h want 1/1/%h", in_ready, out_valid, out_pc, e.pc); else n_pass++;
    sb.push_back('{32'h10, 32'h0020_0193});
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd1) $display("FAIL pp_count: got %0d want 1", count); else n_pass++;
    out_ready = 1'b1;
    e = sb.pop_front();
    n_chk++; if (out_pc !== e.pc || out_ins !== e.ins)
      $display("FAIL pp_head: got %h/%h want %h/%h", out_pc, out_ins, e.pc, e.ins); else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int unsigned i = 0; i < 2; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 32'hF000_0000 | 32'(i), 1'b0);
      sb.push_back('{32'h80 + 32'(4 * i), 32'hF000_0000 | 32'(i)});
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 32'h99, 32'h0000_0099, 1'b1);
    @(negedge CLOCK_50);
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL fl_cycle: got rdy=%b v=%b want 0/0", in_ready, out_valid); else n_pass++;
    tick();
    flush = 1'b0;
    sb.delete();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL fl_after: got cnt=%0d v=%b want 0/0", count, out_valid); else n_pass++;
    n_chk++; if (out_pc !== 32'h0 || out_ins !== 32'h0000_0013)
      $display("FAIL fl_nop: got %h/%h want 0/00000013", out_pc, out_ins); else n_pass++;
    tick();
    drive(1'b1, 32'h30, 32'h0030_0213, 1'b0);
    sb.push_back('{32'h30, 32'h0030_0213});
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge CLOCK_50);
    e = sb.pop_front();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
      $display("FAIL fl_fresh: got v=%b %h/%h want 1 %h/%h", out_valid, out_pc, out_ins, e.pc, e.ins); else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h60, 32'h0060_0013, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h64, 32'h0064_0013, 1'b1);
    @(negedge CLOCK_50);
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rm_during: got rdy=%b v=%b want 0/0", in_ready, out_valid); else n_pass++;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL rm_after: got cnt=%0d v=%b want 0/0", count, out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_halt();
    drive(1'b1, 32'h40, 32'h0040_0293, 1'b0);
    sb.push_back('{32'h40, 32'h0040_0293});
    tick();
    halt = 1'b1;
    drive(1'b1, 32'h44, 32'h0044_0313, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 2'd1)
        $display("FAIL halt%0d: got v=%b rdy=%b cnt=%0d want 0/0/1", i, out_valid, in_ready, count);
      else n_pass++;
      tick();
    end
    halt = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge CLOCK_50);
    e = sb.pop_front();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
      $display("FAIL halt_resume: got v=%b %h/%h want 1 %h/%h", out_valid, out_pc, out_ins, e.pc, e.ins); else n_pass++;
    tick();
    out_ready = 1'b0;
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0) $display("FAIL halt_drain: got %0d want 0", count); else n_pass++;
    tick();
  endtask

`ifdef FDQ_PREDECODE_EN
  task automatic test_predecode();
    @(negedge CLOCK_50);
    n_chk++; if (pd_is_branch !== 1'b0 || pd_is_jump !== 1'b0)
      $display("FAIL pd_empty: got %b/%b want 0/0", pd_is_branch, pd_is_jump); else n_pass++;
    tick();
    drive(1'b1, 32'h50, 32'h0020_8463, 1'b0);
    tick();
    drive(1'b1, 32'h54, 32'h0080_00EF, 1'b0);
    @(negedge CLOCK_50);
    n_chk++; if (pd_is_branch !== 1'b1 || pd_is_jump !== 1'b0)
      $display("FAIL pd_branch: got %b/%b want 1/0", pd_is_branch, pd_is_jump); else n_pass++;
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    out_ready = 1'b0;
    @(negedge CLOCK_50);
    n_chk++; if (pd_is_branch !== 1'b0 || pd_is_jump !== 1'b1)
      $display("FAIL pd_jump: got %b/%b want 0/1", pd_is_branch, pd_is_jump); else n_pass++;
    halt = 1'b1;
    #1;
    n_chk++; if (pd_is_jump !== 1'b0) $display("FAIL pd_gated: got %b want 0", pd_is_jump); else n_pass++;
    tick();
    halt = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_wrap();
    drive(1'b1, 32'h100, 32'hC000_0000, 1'b0);
    sb.push_back('{32'h100, 32'hC000_0000});
    tick();
    for (int unsigned i = 1; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'hC000_0000 | 32'(i), 1'b1);
      @(negedge CLOCK_50);
      e = sb.pop_front();
      n_chk++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
        $display("FAIL wrap%0d: got v=%b %h/%h want 1 %h/%h", i, out_valid, out_pc, out_ins, e.pc, e.ins);
      else n_pass++;
      sb.push_back('{32'h100 + 32'(4 * i), 32'hC000_0000 | 32'(i)});
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge CLOCK_50);
    e = sb.pop_front();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_ins !== e.ins)
      $display("FAIL wrap_last: got v=%b %h/%h want 1 %h/%h", out_valid, out_pc, out_ins, e.pc, e.ins); else n_pass++;
    tick();
    out_ready = 1'b0;
    @(negedge CLOCK_50);
    n_chk++; if (count !== 2'd0 || sb.size() != 0)
      $display("FAIL wrap_end: got cnt=%0d sb=%0d want 0/0", count, sb.size()); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_push_single();
    test_fill();
    test_push_pop_same();
    test_flush();
    test_reset_midstream();
    test_halt();
`ifdef FDQ_PREDECODE_EN
    test_predecode();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
